// File: rtl/rs_chk_pkg.sv
// Shared types and defaults for the RS latch checker.
package rs_chk_pkg;

  localparam int unsigned SETTLE_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF         = 8;

  typedef enum logic [2:0] {
    ST_UNKNOWN  = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_HOLD_CHK = 3'd2,
    ST_FORBID   = 3'd3,
    ST_AMBIG    = 3'd4
  } chk_state_e;

  // NOR latch model: set -> 1, reset -> 0, both -> q forced low, neither -> hold.
  function automatic logic model_q(input logic [1:0] rs, input logic hold_val);
    logic res;
    unique case (rs)
      2'b01:   res = 1'b1;
      2'b10:   res = 1'b0;
      2'b11:   res = 1'b0;
      default: res = hold_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a bundle of asynchronous inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the sampled bundle one stage per clock.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  // Both stages clear on reset so no stale history survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/rs_latch_checker.sv
// Checks an asynchronous RS (NOR) latch against a cycle model after its
// inputs have settled; counts and flags mismatches.
module rs_latch_checker
  import rs_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r,
  input  logic             s,
  input  logic             q,
  input  logic             nq,
  input  logic             clr,
  output logic             exp_q,
  output logic             check_valid,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             forbid_seen,
  output logic [2:0]       state
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [3:0] sync_out;
  logic [1:0] rs_s;
  logic       q_s, nq_s;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({r, s, q, nq}),
    .dout  (sync_out)
  );

  assign rs_s = sync_out[3:2];
  assign q_s  = sync_out[1];
  assign nq_s = sync_out[0];

  chk_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       rs_prev_q, rs_prev_d;
  logic [1:0]       last_rs_q, last_rs_d;
  logic             exp_q_q, exp_q_d;
  logic             check_valid_q, check_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             forbid_seen_q, forbid_seen_d;
  logic             rs_changed, fail;

  // Next-state, model and error bookkeeping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    exp_q_d       = exp_q_q;
    last_rs_d     = last_rs_q;
    rs_prev_d     = rs_s;
    rs_changed    = (rs_s != rs_prev_q);
    fail          = 1'b0;

    if (rs_s != 2'b00) last_rs_d = rs_s;

    // q/nq travel with r/s, so the sample that reveals an rs change may
    // already show the latch reacting; it is not compared.
    unique case (state_q)
      ST_HOLD_CHK: fail = (q_s != exp_q_q) || (nq_s == q_s);
      ST_FORBID:   fail = q_s | nq_s;
      default:     fail = 1'b0;
    endcase
    if (rs_changed) fail = 1'b0;

    if (rs_changed) begin
      state_d = ST_SETTLE;
      cnt_d   = SETTLE_LOAD;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q > 4'd1) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        cnt_d = '0;
        unique case (rs_s)
          2'b01, 2'b10: begin
            state_d = ST_HOLD_CHK;
            exp_q_d = model_q(rs_s, exp_q_q);
          end
          2'b11: begin
            state_d = ST_FORBID;
            exp_q_d = 1'b0;
          end
          default: begin
            unique case (last_rs_q)
              2'b01, 2'b10: begin
                state_d = ST_HOLD_CHK;
                exp_q_d = model_q(last_rs_q, exp_q_q);
              end
              2'b11:   state_d = ST_AMBIG;
              default: state_d = ST_UNKNOWN;
            endcase
          end
        endcase
      end
    end

    check_valid_d = (state_d == ST_HOLD_CHK) || (state_d == ST_FORBID);
    err_d         = fail;

    if (clr)
      err_count_d = '0;
    else if (fail && (err_count_q != '1))
      err_count_d = err_count_q + 1'b1;
    else
      err_count_d = err_count_q;

    forbid_seen_d = clr ? 1'b0 : forbid_seen_q;
    if ((state_d == ST_FORBID) && (state_q != ST_FORBID)) forbid_seen_d = 1'b1;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_UNKNOWN;
      cnt_q         <= '0;
      rs_prev_q     <= '0;
      last_rs_q     <= '0;
      exp_q_q       <= 1'b0;
      check_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      forbid_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rs_prev_q     <= rs_prev_d;
      last_rs_q     <= last_rs_d;
      exp_q_q       <= exp_q_d;
      check_valid_q <= check_valid_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      forbid_seen_q <= forbid_seen_d;
    end
  end

  assign exp_q       = exp_q_q;
  assign check_valid = check_valid_q;
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign forbid_seen = forbid_seen_q;
  assign state       = state_q;

endmodule

// File: tb/tb_rs_latch_checker.sv
// Directed bench for rs_latch_checker with a behavioural NOR latch driving q/nq.
module tb_rs_latch_checker;

  localparam logic [2:0] S_UNK = 3'd0, S_SET = 3'd1, S_HLD = 3'd2, S_FRB = 3'd3, S_AMB = 3'd4;

  logic clk, rst_n, r, s, q, nq, clr;
  logic       exp_q, check_valid, err, forbid_seen;
  logic [7:0] err_count;
  logic [2:0] state;
  logic       exp_q2, check_valid2, err2, forbid_seen2;
  logic [1:0] err_count2;
  logic [2:0] state2;
  logic       lat;
  logic       rv;
  int tests, fails;

  rs_latch_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .r(r), .s(s), .q(q), .nq(nq), .clr(clr),
    .exp_q(exp_q), .check_valid(check_valid), .err(err),
    .err_count(err_count), .forbid_seen(forbid_seen), .state(state)
  );

  rs_latch_checker #(.SETTLE_CYCLES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .r(r), .s(s), .q(q), .nq(nq), .clr(clr),
    .exp_q(exp_q2), .check_valid(check_valid2), .err(err2),
    .err_count(err_count2), .forbid_seen(forbid_seen2), .state(state2)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive r/s and let the latch model respond.
  task automatic set_rs(input logic rr, input logic ss);
    r = rr;
    s = ss;
    if (rr && ss) begin lat = 1'b0; q = 1'b0; nq = 1'b0; end
    else if (ss)  begin lat = 1'b1; q = 1'b1; nq = 1'b0; end
    else if (rr)  begin lat = 1'b0; q = 1'b0; nq = 1'b1; end
    else          begin q = lat; nq = ~lat; end
  endtask

  task automatic set_q(input logic qq, input logic nn);
    q  = qq;
    nq = nn;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    clk = 1'b0; rst_n = 1'b0; clr = 1'b0; lat = 1'b0;
    set_rs(1'b0, 1'b0);
    tick(2);
    chk("rst_state", 32'(state), 32'(S_UNK));
    chk("rst_expq", 32'(exp_q), 0);
    chk("rst_cv", 32'(check_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(err_count), 0);
    chk("rst_forbid", 32'(forbid_seen), 0);

    // Set held: sync, detect, two settle cycles, then checking.
    rst_n = 1'b1;
    set_rs(1'b0, 1'b1);
    tick(4);
    chk("set_settle", 32'(state), 32'(S_SET));
    chk("set_settle_cv", 32'(check_valid), 0);
    tick(1);
    chk("set_hold", 32'(state), 32'(S_HLD));
    chk("set_expq", 32'(exp_q), 1);
    chk("set_cv", 32'(check_valid), 1);
    tick(1);
    chk("set_err", 32'(err), 0);

    // 01 -> 11 -> 10 with a correct latch.
    set_rs(1'b1, 1'b1);
    tick(5);
    chk("frb_state", 32'(state), 32'(S_FRB));
    chk("frb_seen", 32'(forbid_seen), 1);
    chk("frb_expq", 32'(exp_q), 0);
    chk("frb_cv", 32'(check_valid), 1);
    tick(1);
    chk("frb_err", 32'(err), 0);
    set_rs(1'b1, 1'b0);
    tick(5);
    chk("rst10_state", 32'(state), 32'(S_HLD));
    chk("rst10_expq", 32'(exp_q), 0);
    tick(1);
    chk("rst10_err", 32'(err), 0);
    chk("rst10_cnt", 32'(err_count), 0);

    // 11 -> 00 is ambiguous until a defined input arrives.
    set_rs(1'b1, 1'b1);
    tick(5);
    chk("amb_pre", 32'(state), 32'(S_FRB));
    set_rs(1'b0, 1'b0);
    tick(5);
    chk("amb_state", 32'(state), 32'(S_AMB));
    chk("amb_cv", 32'(check_valid), 0);
    tick(3);
    chk("amb_stay", 32'(state), 32'(S_AMB));
    chk("amb_err", 32'(err), 0);
    set_rs(1'b1, 1'b0);
    tick(5);
    chk("amb_exit", 32'(state), 32'(S_HLD));
    chk("amb_exit_expq", 32'(exp_q), 0);
    tick(1);
    chk("amb_exit_err", 32'(err), 0);

    // 01 -> 00 holds the set value.
    set_rs(1'b0, 1'b1);
    tick(5);
    chk("hold_pre_expq", 32'(exp_q), 1);
    set_rs(1'b0, 1'b0);
    tick(5);
    chk("hold_state", 32'(state), 32'(S_HLD));
    chk("hold_expq", 32'(exp_q), 1);
    chk("hold_cv", 32'(check_valid), 1);
    tick(1);
    chk("hold_err", 32'(err), 0);

    // q stuck low for three samples while set is held.
    set_rs(1'b0, 1'b1);
    tick(5);
    chk("f3_pre", 32'(state), 32'(S_HLD));
    set_q(1'b0, 1'b1);
    tick(3);
    chk("f3_err1", 32'(err), 1);
    set_rs(1'b0, 1'b1);
    tick(1);
    chk("f3_err2", 32'(err), 1);
    chk("f3_cnt2", 32'(err_count), 2);
    tick(1);
    chk("f3_err3", 32'(err), 1);
    chk("f3_cnt3", 32'(err_count), 3);
    tick(1);
    chk("f3_err_off", 32'(err), 0);
    chk("f3_cnt_hold", 32'(err_count), 3);
    chk("f3_cnt_w2", 32'(err_count2), 3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_cnt", 32'(err_count), 0);
    chk("clr_forbid", 32'(forbid_seen), 0);
    chk("clr_cnt_w2", 32'(err_count2), 0);

    // r toggling every cycle keeps the checker settling.
    rv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rv = ~rv;
      set_rs(rv, 1'b1);
      tick(1);
      if (i >= 2) chk("tog_settle", 32'(state), 32'(S_SET));
      chk("tog_err", 32'(err), 0);
    end
    tick(3);
    chk("tog_tail", 32'(state), 32'(S_SET));
    tick(1);
    chk("tog_resume", 32'(state), 32'(S_HLD));
    chk("tog_expq", 32'(exp_q), 1);
    tick(1);
    chk("tog_err_after", 32'(err), 0);
    chk("tog_forbid", 32'(forbid_seen), 0);

    // Persistent mismatch: narrow counter saturates.
    set_q(1'b0, 1'b1);
    tick(7);
    chk("sat_cnt8", 32'(err_count), 5);
    chk("sat_cnt2", 32'(err_count2), 3);
    tick(1);
    chk("sat_cnt8b", 32'(err_count), 6);
    chk("sat_cnt2b", 32'(err_count2), 3);
    chk("sat_err2", 32'(err2), 1);

    // Reset in the middle of a settle window.
    set_rs(1'b1, 1'b0);
    tick(3);
    chk("mid_settle", 32'(state), 32'(S_SET));
    rst_n = 1'b0;
    tick(1);
    chk("mr_state", 32'(state), 32'(S_UNK));
    chk("mr_state2", 32'(state2), 32'(S_UNK));
    chk("mr_cnt", 32'(err_count), 0);
    chk("mr_cnt2", 32'(err_count2), 0);
    chk("mr_err", 32'(err | err2), 0);
    chk("mr_cv", 32'(check_valid | check_valid2), 0);
    chk("mr_expq", 32'(exp_q | exp_q2), 0);
    chk("mr_forbid", 32'(forbid_seen | forbid_seen2), 0);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst", 32'(state), 32'(S_UNK));
    chk("post_rst_cv", 32'(check_valid), 0);
    tick(4);
    chk("post_hold", 32'(state), 32'(S_HLD));
    chk("post_expq", 32'(exp_q), 0);
    tick(1);
    chk("post_err", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_latch_checker.md
RS_LATCH_CHECKER -- requirements
Module: rs_latch_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: clk cycles allowed for q/nq to settle after a synchronised r/s change; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of err_count.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 r  input  1  latch reset input, asynchronous to clk.
REQ-006 s  input  1  latch set input, asynchronous to clk.
REQ-007 q  input  1  latch output under check, asynchronous.
REQ-008 nq  input  1  latch complementary output under check, asynchronous.
REQ-009 clr  input  1  synchronous clear of err_count and forbid_seen.
REQ-010 exp_q  output  1  model-expected q, valid only when check_valid=1.
REQ-011 check_valid  output  1  high in cycles where a comparison is performed.
REQ-012 err  output  1  high for each cycle a comparison fails.
REQ-013 err_count  output  CNT_W  saturating count of failing cycles.
REQ-014 forbid_seen  output  1  sticky flag: r=s=1 observed.
REQ-015 state  output  3  current FSM state encoding.

Function
REQ-016 r, s, q, nq SHALL pass together through a 2-flop synchroniser; all decisions use synchronised values (2-cycle input latency).
REQ-017 States SHALL be UNKNOWN, SETTLE, HOLD_CHK, FORBID, AMBIG.
REQ-018 Latch model (NOR type): rs=01 -> exp 1; 10 -> exp 0; 00 -> hold exp; 11 -> q=nq=0 expected.
REQ-019 Any change of synchronised {r,s} vs previous cycle SHALL enter SETTLE and load settle counter with SETTLE_CYCLES.
REQ-020 A further {r,s} change during SETTLE SHALL reload the counter; no comparison in SETTLE.
REQ-021 On counter reaching 0: rs=01/10 -> HOLD_CHK; rs=11 -> FORBID; rs=00 -> HOLD_CHK if prior defined rs was 01/10 and no 11 since, AMBIG if coming from 11, UNKNOWN if no defined value since reset.
REQ-022 HOLD_CHK: check_valid=1; fail when q!=exp_q or nq!=~q.
REQ-023 FORBID: check_valid=1; exp_q=0; fail unless q=0 and nq=0; forbid_seen set on entry.
REQ-024 AMBIG and UNKNOWN: check_valid=0, err=0; leave only via an {r,s} change through SETTLE.
REQ-025 err SHALL be registered, asserted the cycle after the failing sample; err_count increments same edge, saturating at 2^CNT_W-1.
REQ-026 clr and increment in same cycle: clr wins, count becomes 0; forbid_seen still set if FORBID entered that cycle.

Reset
REQ-027 rst_n=0 at posedge clk SHALL force: state=UNKNOWN, exp_q=0, check_valid=0, err=0, err_count=0, forbid_seen=0, settle counter=0, synchroniser flops=0.
REQ-028 Reset mid-SETTLE or mid-FORBID SHALL discard all history; first cycle after release is UNKNOWN.

Structure
REQ-029 Shared package rs_chk_pkg SHALL hold the state enum and SETTLE_CYCLES/CNT_W defaults.
REQ-030 Sub-module sync2 (parameterised width, 2 flops, synchronous active-low reset) SHALL implement the synchroniser.

Verification (SETTLE_CYCLES=2, NOR latch model attached)
REQ-031 Reset, then rs=01 held -> after 2 sync + 2 settle cycles state=HOLD_CHK, exp_q=1, check_valid=1, err=0.
REQ-032 rs 01->11->10 with correct latch -> forbid_seen=1, FORBID checks q=nq=0 pass, then HOLD_CHK exp_q=0, err_count=0.
REQ-033 rs 11->00 -> state=AMBIG, check_valid=0 until rs=10 applied, then HOLD_CHK exp_q=0.
REQ-034 Force q=0 while rs=01 held 3 cycles -> err high 3 cycles, err_count=3; clr -> err_count=0.
REQ-035 Toggle r every cycle for 6 cycles -> state stays SETTLE, no err; stop toggling -> checks resume after 2 cycles.
REQ-036 CNT_W=2, force persistent mismatch -> err_count saturates at 3; rst_n=0 mid-SETTLE -> all outputs 0, state=UNKNOWN.
